// File: rtl/fetch_pkg.sv
// Counter encodings, bubble instruction and BTB geometry helpers shared by
// the fetch/predict stage and its branch target buffer.
package fetch_pkg;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   localparam logic [31:0] NOP_INSTR = 32'h0;

   function automatic int btb_idx_w(input int depth);
      return $clog2(depth);
   endfunction

   // Tag covers everything above the index and the word offset.
   function automatic int btb_tag_w(input int xlen, input int depth);
      return xlen - $clog2(depth) - 2;
   endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Works on word addresses (PC[XLEN-1:2]); lookup is combinational, update at the edge.
module fetch_btb
   import fetch_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BTB_DEPTH = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-3:0] lookup_word,
   output logic            hit_taken,
   output logic [XLEN-3:0] hit_target,
   input  logic            upd_valid,
   input  logic [XLEN-3:0] upd_word,
   input  logic            upd_is_jump,
   input  logic            upd_taken,
   input  logic [XLEN-3:0] upd_target
);

   localparam int IW = btb_idx_w(BTB_DEPTH);
   localparam int TW = btb_tag_w(XLEN, BTB_DEPTH);

   logic [BTB_DEPTH-1:0] valid_q;
   logic [TW-1:0]        tag_q    [BTB_DEPTH];
   logic [XLEN-3:0]      target_q [BTB_DEPTH];
   logic [1:0]           ctr_q    [BTB_DEPTH];

   logic [IW-1:0] lk_idx;
   logic [TW-1:0] lk_tag;
   logic [IW-1:0] up_idx;
   logic [TW-1:0] up_tag;
   logic          up_hit;

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == ST) ? ST : c + 2'd1;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] c);
      return (c == SNT) ? SNT : c - 2'd1;
   endfunction

   assign lk_idx = lookup_word[IW-1:0];
   assign lk_tag = lookup_word[XLEN-3:IW];
   assign up_idx = upd_word[IW-1:0];
   assign up_tag = upd_word[XLEN-3:IW];
   assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

   assign hit_taken  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && ctr_q[lk_idx][1];
   assign hit_target = target_q[lk_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (upd_valid && !up_hit && upd_taken) begin
         valid_q[up_idx] <= 1'b1;
      end
   end

   // A miss that was not taken leaves the entry (and any alias in it) alone.
   always_ff @(posedge clk) begin
      if (upd_valid && (up_hit || upd_taken)) begin
         tag_q[up_idx] <= up_tag;
         if (upd_taken) target_q[up_idx] <= upd_target;
         if (upd_is_jump)    ctr_q[up_idx] <= ST;
         else if (!up_hit)   ctr_q[up_idx] <= WT;
         else if (upd_taken) ctr_q[up_idx] <= sat_inc(ctr_q[up_idx]);
         else                ctr_q[up_idx] <= sat_dec(ctr_q[up_idx]);
      end
   end

endmodule

// File: rtl/fetch_predict_unit.sv
// Fetch stage: PC register, IF/ID register and branch prediction with mispredict repair.
// Define FETCH_BTB_EN to build the BTB predictor; otherwise fetch is static not-taken.
module fetch_predict_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter int              BTB_DEPTH = 16,
   parameter logic [XLEN-1:0] RESET_PC  = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            freeze,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     id_instr,
   output logic [XLEN-1:0] id_pc_plus4,
   output logic            id_valid,
   output logic            id_pred_taken,
   output logic [XLEN-1:0] id_pred_target,
   input  logic            res_valid,
   input  logic [XLEN-1:0] res_pc,
   input  logic            res_is_jump,
   input  logic            res_taken,
   input  logic [XLEN-1:0] res_target,
   input  logic            res_pred_taken,
   input  logic [XLEN-1:0] res_pred_target,
   output logic            flush
);

   logic [XLEN-1:0] pc_p0;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] next_pc;
   logic [XLEN-1:0] redirect_pc;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;

   logic [31:0]     instr_p1;
   logic [XLEN-1:0] pc_plus4_p1;
   logic            vld_p1;
   logic            pred_taken_p1;
   logic [XLEN-1:0] pred_target_p1;

   assign pc_plus4 = pc_p0 + XLEN'(4);

`ifdef FETCH_BTB_EN
   logic [XLEN-1:0] res_pc_plus4;
   logic [XLEN-1:0] res_pred_next;
   logic            btb_taken;
   logic [XLEN-3:0] btb_target;

   assign res_pc_plus4  = res_pc + XLEN'(4);
   assign redirect_pc   = res_taken ? res_target : res_pc_plus4;
   assign res_pred_next = res_pred_taken ? res_pred_target : res_pc_plus4;
   assign flush         = res_valid && (redirect_pc != res_pred_next);

   fetch_btb #(
      .XLEN      (XLEN),
      .BTB_DEPTH (BTB_DEPTH)
   ) u_btb (
      .clk         (clk),
      .rst         (rst),
      .lookup_word (pc_p0[XLEN-1:2]),
      .hit_taken   (btb_taken),
      .hit_target  (btb_target),
      .upd_valid   (res_valid),
      .upd_word    (res_pc[XLEN-1:2]),
      .upd_is_jump (res_is_jump),
      .upd_taken   (res_taken),
      .upd_target  (res_target[XLEN-1:2])
   );

   assign pred_taken  = btb_taken;
   assign pred_target = btb_taken ? {btb_target, 2'b00} : '0;
`else
   // Without a predictor only a taken branch can be mispredicted.
   logic unused_res;

   assign unused_res  = ^{res_pc, res_is_jump, res_pred_taken, res_pred_target};
   assign redirect_pc = res_target;
   assign flush       = res_valid && res_taken;
   assign pred_taken  = 1'b0;
   assign pred_target = '0;
`endif

   always_comb begin
      next_pc = pc_plus4;
      if (flush)           next_pc = redirect_pc;
      else if (freeze)     next_pc = pc_p0;
      else if (pred_taken) next_pc = pred_target;
   end

   // Stage 0: program counter
   always_ff @(posedge clk) begin
      if (rst) pc_p0 <= RESET_PC;
      else     pc_p0 <= next_pc;
   end

   // Stage 1: IF/ID register; a flush inserts a bubble even while frozen
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_p1       <= NOP_INSTR;
         pc_plus4_p1    <= '0;
         vld_p1         <= 1'b0;
         pred_taken_p1  <= 1'b0;
         pred_target_p1 <= '0;
      end else if (flush) begin
         instr_p1       <= NOP_INSTR;
         vld_p1         <= 1'b0;
         pred_taken_p1  <= 1'b0;
         pred_target_p1 <= '0;
      end else if (!freeze) begin
         instr_p1       <= imem_rdata;
         pc_plus4_p1    <= pc_plus4;
         vld_p1         <= 1'b1;
         pred_taken_p1  <= pred_taken;
         pred_target_p1 <= pred_target;
      end
   end

   assign imem_addr      = pc_p0;
   assign id_instr       = instr_p1;
   assign id_pc_plus4    = pc_plus4_p1;
   assign id_valid       = vld_p1;
   assign id_pred_taken  = pred_taken_p1;
   assign id_pred_target = pred_target_p1;

endmodule

// File: tb/tb_fetch_predict_unit.sv
// Directed bench for fetch_predict_unit; expectations depend on whether FETCH_BTB_EN is defined.
module tb_fetch_predict_unit;

   localparam int          XLEN      = 32;
   localparam int          BTB_DEPTH = 16;
   localparam logic [31:0] RESET_PC  = 32'h100;
`ifdef FETCH_BTB_EN
   localparam logic BTB = 1'b1;
`else
   localparam logic BTB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, freeze;
   logic [31:0] imem_addr, imem_rdata, id_instr, id_pc_plus4, id_pred_target;
   logic        id_valid, id_pred_taken, flush;
   logic        res_valid, res_is_jump, res_taken, res_pred_taken;
   logic [31:0] res_pc, res_target, res_pred_target;

   typedef struct {
      logic [31:0] pc;
      logic        vld;
      logic [31:0] ipc;
      logic        pt;
      logic [31:0] ptgt;
      logic        in_rst;
   } exp_t;

   exp_t sbq[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   fetch_predict_unit #(
      .XLEN(XLEN), .BTB_DEPTH(BTB_DEPTH), .RESET_PC(RESET_PC)
   ) dut (
      .clk(clk), .rst(rst), .freeze(freeze),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .id_instr(id_instr), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid),
      .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
      .res_valid(res_valid), .res_pc(res_pc), .res_is_jump(res_is_jump),
      .res_taken(res_taken), .res_target(res_target),
      .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
      .flush(flush)
   );

   task automatic idle();
      res_valid = 1'b0; res_pc = '0; res_is_jump = 1'b0; res_taken = 1'b0;
      res_target = '0; res_pred_taken = 1'b0; res_pred_target = '0;
   endtask

   task automatic resolve(input logic [31:0] pc, input logic jmp, input logic tk,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ptg);
      res_valid = 1'b1; res_pc = pc; res_is_jump = jmp; res_taken = tk;
      res_target = tgt; res_pred_taken = ptk; res_pred_target = ptg;
   endtask

   // Check flush before the edge, queue the post-edge expectation, then clock and compare.
   task automatic go(input logic chk_fl, input logic e_fl, input logic [31:0] e_pc,
                     input logic e_vld, input logic [31:0] e_ipc, input logic e_pt,
                     input logic [31:0] e_ptgt);
      exp_t e;
      logic [31:0] w_instr, w_p4, w_tgt;
      #1;
      if (chk_fl) begin
         tests++;
         assert (flush === e_fl) else begin
            fails++; $error("FAIL flush pc=%h: got %b want %b", res_pc, flush, e_fl);
         end
      end
      sbq.push_back('{pc: e_pc, vld: e_vld, ipc: e_ipc, pt: e_pt, ptgt: e_ptgt, in_rst: rst});
      @(posedge clk);
      #1;
      e       = sbq.pop_front();
      w_instr = e.vld ? mem_word(e.ipc) : 32'h0;
      w_p4    = e.ipc + 32'd4;
      w_tgt   = e.vld ? e.ptgt : 32'h0;
      tests++;
      assert (imem_addr === e.pc) else begin
         fails++; $error("FAIL imem_addr: got %h want %h", imem_addr, e.pc);
      end
      tests++;
      assert (id_valid === e.vld) else begin
         fails++; $error("FAIL id_valid @%h: got %b want %b", e.pc, id_valid, e.vld);
      end
      tests++;
      assert (id_instr === w_instr) else begin
         fails++; $error("FAIL id_instr @%h: got %h want %h", e.pc, id_instr, w_instr);
      end
      tests++;
      assert (id_pred_taken === (e.vld & e.pt)) else begin
         fails++; $error("FAIL id_pred_taken @%h: got %b want %b", e.pc, id_pred_taken, e.vld & e.pt);
      end
      tests++;
      assert (id_pred_target === w_tgt) else begin
         fails++; $error("FAIL id_pred_target @%h: got %h want %h", e.pc, id_pred_target, w_tgt);
      end
      if (e.vld) begin
         tests++;
         assert (id_pc_plus4 === w_p4) else begin
            fails++; $error("FAIL id_pc_plus4 @%h: got %h want %h", e.pc, id_pc_plus4, w_p4);
         end
      end else if (e.in_rst) begin
         tests++;
         assert (id_pc_plus4 === 32'h0) else begin
            fails++; $error("FAIL id_pc_plus4 reset: got %h want 0", id_pc_plus4);
         end
      end
   endtask

   initial begin
      rst = 1'b1; freeze = 1'b0; idle();
      // reset
      go(1, 0, 32'h100, 0, 0, 0, 0);
      go(1, 0, 32'h100, 0, 0, 0, 0);
      rst = 1'b0;
      // sequential fetch from RESET_PC
      go(1, 0, 32'h104, 1, 32'h100, 0, 0);
      go(1, 0, 32'h108, 1, 32'h104, 0, 0);
      go(1, 0, 32'h10c, 1, 32'h108, 0, 0);
      // redirect to 0x20, then branch at 0x20 taken to 0x80 on a cold BTB
      resolve(32'h108, 0, 1, 32'h20, 0, 0); go(1, 1, 32'h20, 0, 0, 0, 0);
      idle();                               go(1, 0, 32'h24, 1, 32'h20, 0, 0);
      resolve(32'h20, 0, 1, 32'h80, 0, 0);  go(1, 1, 32'h80, 0, 0, 0, 0);
      idle();                               go(1, 0, 32'h84, 1, 32'h80, 0, 0);
      resolve(32'h84, 0, 1, 32'h20, 0, 0);  go(1, 1, 32'h20, 0, 0, 0, 0);
      // re-fetch of 0x20 predicts taken to 0x80
      idle();
      go(1, 0, BTB ? 32'h80 : 32'h24, 1, 32'h20, BTB, BTB ? 32'h80 : 32'h0);
      // two not-taken resolutions: ctr 2 -> 1 -> 0
      resolve(32'h20, 0, 0, 0, BTB, BTB ? 32'h80 : 32'h0);
      go(1, BTB, BTB ? 32'h24 : 32'h28, !BTB, BTB ? 32'h0 : 32'h24, 0, 0);
      resolve(32'h20, 0, 0, 0, 0, 0);
      go(1, 0, BTB ? 32'h28 : 32'h2c, 1, BTB ? 32'h24 : 32'h28, 0, 0);
      resolve(32'h84, 0, 1, 32'h20, 0, 0);  go(1, 1, 32'h20, 0, 0, 0, 0);
      idle();                               go(1, 0, 32'h24, 1, 32'h20, 0, 0);
      // freeze holds PC and IF/ID; flush beats freeze
      freeze = 1'b1;
      for (int i = 0; i < 3; i++) go(1, 0, 32'h24, 1, 32'h20, 0, 0);
      resolve(32'h20, 0, 1, 32'h80, 0, 0);  go(1, 1, 32'h80, 0, 0, 0, 0);
      freeze = 1'b0; idle();                go(1, 0, 32'h84, 1, 32'h80, 0, 0);
      // aliasing: 0x60 shares the index of 0x20
      resolve(32'h20, 0, 1, 32'h80, 0, 0);  go(1, 1, 32'h80, 0, 0, 0, 0);
      resolve(32'h7c, 0, 1, 32'h60, 0, 0);  go(1, 1, 32'h60, 0, 0, 0, 0);
      idle();                               go(1, 0, 32'h64, 1, 32'h60, 0, 0);
      resolve(32'h60, 0, 1, 32'h200, 0, 0); go(1, 1, 32'h200, 0, 0, 0, 0);
      resolve(32'h1fc, 0, 1, 32'h20, 0, 0); go(1, 1, 32'h20, 0, 0, 0, 0);
      idle();                               go(1, 0, 32'h24, 1, 32'h20, 0, 0);
      resolve(32'h24, 0, 1, 32'h60, 0, 0);  go(1, 1, 32'h60, 0, 0, 0, 0);
      idle();
      go(1, 0, BTB ? 32'h200 : 32'h64, 1, 32'h60, BTB, BTB ? 32'h200 : 32'h0);
      // reset during a redirect; BTB contents are discarded
      rst = 1'b1; resolve(32'h60, 0, 1, 32'h300, 0, 0); go(0, 0, 32'h100, 0, 0, 0, 0);
      rst = 1'b0; resolve(32'h108, 0, 1, 32'h60, 0, 0); go(1, 1, 32'h60, 0, 0, 0, 0);
      idle();                               go(1, 0, 32'h64, 1, 32'h60, 0, 0);
      // PC+4 wraps at the top of the address space
      resolve(32'h64, 0, 1, 32'hFFFF_FFFC, 0, 0); go(1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
      idle();                               go(1, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 0);
      // a jump allocates strongly taken, so one not-taken still predicts taken
      resolve(32'h300, 1, 1, 32'h400, 0, 0); go(1, 1, 32'h400, 0, 0, 0, 0);
      resolve(32'h300, 0, 0, 0, 0, 0);       go(1, 0, 32'h404, 1, 32'h400, 0, 0);
      resolve(32'h3fc, 0, 1, 32'h300, 0, 0); go(1, 1, 32'h300, 0, 0, 0, 0);
      idle();
      go(1, 0, BTB ? 32'h400 : 32'h304, 1, 32'h300, BTB, BTB ? 32'h400 : 32'h0);
      // correctly predicted taken jump: no flush with the BTB, one bubble without
      resolve(32'h300, 1, 1, 32'h400, BTB, BTB ? 32'h400 : 32'h0);
      go(1, !BTB, BTB ? 32'h404 : 32'h400, BTB, BTB ? 32'h400 : 32'h0, 0, 0);
      idle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
